ex_mem_reg: RTL and testbench

//  EX/MEM pipeline register of the 5-stage pipelined processor.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_reg.sv | 35 +++
 rtl/ex_mem_reg.sv | 120 ++++++++++++
 tb/tb_ex_mem_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline package: bus widths and the MEM/WB control bundle that
// travels with an instruction through ID/EX, EX/MEM and MEM/WB.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    // Control bits carried from decode down to writeback
    typedef struct packed {
        logic RegWrite;
        logic MemRead;
        logic MemWrite;
        logic MemToReg;
        logic Branchs;
        logic Jumps;
    } exmem_ctrl_t;

    localparam int CTRL_W = $bits(exmem_ctrl_t);

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register slice: asynchronous active-low clear to zero,
// loads on the rising edge only while enable is high, otherwise holds.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Stall keeps the stored value; otherwise the new input is taken
    always_comb begin
        data_d = data_q;
        if (enable) begin
            data_d = d_i;
        end
    end

    // Storage element, cleared immediately whenever reset_n drops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: latches execute-stage results and control bits
// for the memory stage, one cycle of latency, with stall via enable.
// Optional macro EXMEM_FLUSH_EN adds a flush input that turns the captured
// instruction into a bubble (control, zero flag and destination cleared).
module ex_mem_reg #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RD_W   = pipe_pkg::RD_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
`ifdef EXMEM_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [DATA_W-1:0] iIR,
    input  logic [DATA_W-1:0] iPC,
    input  logic [DATA_W-1:0] iResult,
    input  logic [DATA_W-1:0] iBranch,
    input  logic [DATA_W-1:0] iJump,
    input  logic              iZero,
    input  logic              iRegWrite,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iMemToReg,
    input  logic              iBranchs,
    input  logic              iJumps,
    input  logic [RD_W-1:0]   iRegDest,
    output logic [DATA_W-1:0] oIR,
    output logic [DATA_W-1:0] oPC,
    output logic [DATA_W-1:0] oResult,
    output logic [DATA_W-1:0] oBranch,
    output logic [DATA_W-1:0] oJump,
    output logic              oZero,
    output logic              oRegWrite,
    output logic              oMemRead,
    output logic              oMemWrite,
    output logic              oMemToReg,
    output logic              oBranchs,
    output logic              oJumps,
    output logic [RD_W-1:0]   oRegDest
);

    import pipe_pkg::*;

    localparam int DataGroupW = 5 * DATA_W;
    localparam int FlagGroupW = CTRL_W + 1;

    exmem_ctrl_t           ctrlIn;
    exmem_ctrl_t           ctrlOut;
    logic [DataGroupW-1:0] data_d;
    logic [DataGroupW-1:0] data_q;
    logic [FlagGroupW-1:0] flags_d;
    logic [FlagGroupW-1:0] flags_q;
    logic [RD_W-1:0]       regDest_d;
    logic [RD_W-1:0]       regDest_q;

    assign ctrlIn = '{
        RegWrite: iRegWrite,
        MemRead:  iMemRead,
        MemWrite: iMemWrite,
        MemToReg: iMemToReg,
        Branchs:  iBranchs,
        Jumps:    iJumps
    };

    assign data_d = {iIR, iPC, iResult, iBranch, iJump};

`ifdef EXMEM_FLUSH_EN
    // A flushed instruction keeps its data buses but loses every side effect
    always_comb begin
        flags_d   = {ctrlIn, iZero};
        regDest_d = iRegDest;
        if (flush) begin
            flags_d   = '0;
            regDest_d = '0;
        end
    end
`else
    // Without flush support everything passes straight into the register
    always_comb begin
        flags_d   = {ctrlIn, iZero};
        regDest_d = iRegDest;
    end
`endif

    pipe_reg #(.W(DataGroupW)) uDataReg (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .d_i     (data_d),
        .q_o     (data_q)
    );

    pipe_reg #(.W(FlagGroupW)) uFlagReg (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .d_i     (flags_d),
        .q_o     (flags_q)
    );

    pipe_reg #(.W(RD_W)) uRegDestReg (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .d_i     (regDest_d),
        .q_o     (regDest_q)
    );

    assign {oIR, oPC, oResult, oBranch, oJump} = data_q;
    assign {ctrlOut, oZero}                     = flags_q;
    assign oRegWrite = ctrlOut.RegWrite;
    assign oMemRead  = ctrlOut.MemRead;
    assign oMemWrite = ctrlOut.MemWrite;
    assign oMemToReg = ctrlOut.MemToReg;
    assign oBranchs  = ctrlOut.Branchs;
    assign oJumps    = ctrlOut.Jumps;
    assign oRegDest  = regDest_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg. Directed cases followed by random
// traffic, compared against a transaction-level model of the register.
// Define EXMEM_FLUSH_EN to also exercise the flush input.
module tb_ex_mem_reg;

    // One pipeline slot: everything the register carries for an instruction
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] br;
        logic [31:0] jp;
        logic        zero;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        bs;
        logic        js;
        logic [4:0]  rd;
    } slot_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
`ifdef EXMEM_FLUSH_EN
    logic        flush;
`endif
    slot_t       stim;
    slot_t       expSlot;
    slot_t       case2;
    slot_t       scratch;
    logic [31:0] oIR, oPC, oResult, oBranch, oJump;
    logic        oZero, oRegWrite, oMemRead, oMemWrite, oMemToReg, oBranchs, oJumps;
    logic [4:0]  oRegDest;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    ex_mem_reg dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
`ifdef EXMEM_FLUSH_EN
        .flush     (flush),
`endif
        .iIR       (stim.ir),
        .iPC       (stim.pc),
        .iResult   (stim.res),
        .iBranch   (stim.br),
        .iJump     (stim.jp),
        .iZero     (stim.zero),
        .iRegWrite (stim.rw),
        .iMemRead  (stim.mr),
        .iMemWrite (stim.mw),
        .iMemToReg (stim.m2r),
        .iBranchs  (stim.bs),
        .iJumps    (stim.js),
        .iRegDest  (stim.rd),
        .oIR       (oIR),
        .oPC       (oPC),
        .oResult   (oResult),
        .oBranch   (oBranch),
        .oJump     (oJump),
        .oZero     (oZero),
        .oRegWrite (oRegWrite),
        .oMemRead  (oMemRead),
        .oMemWrite (oMemWrite),
        .oMemToReg (oMemToReg),
        .oBranchs  (oBranchs),
        .oJumps    (oJumps),
        .oRegDest  (oRegDest)
    );

    function automatic slot_t randSlot();
        slot_t s;
        s.ir   = $urandom;
        s.pc   = $urandom;
        s.res  = $urandom;
        s.br   = $urandom;
        s.jp   = $urandom;
        s.zero = 1'($urandom_range(0, 1));
        s.rw   = 1'($urandom_range(0, 1));
        s.mr   = 1'($urandom_range(0, 1));
        s.mw   = 1'($urandom_range(0, 1));
        s.m2r  = 1'($urandom_range(0, 1));
        s.bs   = 1'($urandom_range(0, 1));
        s.js   = 1'($urandom_range(0, 1));
        s.rd   = 5'($urandom_range(0, 31));
        return s;
    endfunction

    // Model of one rising edge: a stall keeps the old slot, a flushed load
    // keeps only the data buses, a normal load copies the whole slot
    function automatic slot_t modelEdge(slot_t held, slot_t in, logic en, logic fl);
        slot_t n;
        if (!en) return held;
        n = in;
        if (fl) begin
            n.zero = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
            n.m2r = 1'b0;  n.bs = 1'b0; n.js = 1'b0; n.rd = 5'd0;
        end
        return n;
    endfunction

    // Compare DUT outputs against the model in three groups
    task automatic checkOutput(input string tag);
        logic [159:0] obsData, expData;
        logic [6:0]   obsFlags, expFlags;
        obsData  = {oIR, oPC, oResult, oBranch, oJump};
        expData  = {expSlot.ir, expSlot.pc, expSlot.res, expSlot.br, expSlot.jp};
        obsFlags = {oZero, oRegWrite, oMemRead, oMemWrite, oMemToReg, oBranchs, oJumps};
        expFlags = {expSlot.zero, expSlot.rw, expSlot.mr, expSlot.mw,
                    expSlot.m2r, expSlot.bs, expSlot.js};
        total++;
        assert (obsData === expData) else begin
            bad++;
            $error("[TB] FAIL %s.data observed=%h expected=%h", tag, obsData, expData);
        end
        total++;
        assert (obsFlags === expFlags) else begin
            bad++;
            $error("[TB] FAIL %s.flags observed=%b expected=%b", tag, obsFlags, expFlags);
        end
        total++;
        assert (oRegDest === expSlot.rd) else begin
            bad++;
            $error("[TB] FAIL %s.regdest observed=%h expected=%h", tag, oRegDest, expSlot.rd);
        end
    endtask

    // Drive a slot between edges, let one rising edge happen, then check
    task automatic applyStimulus(input slot_t s, input logic en, input logic fl, input string tag);
        @(negedge clock);
        stim   = s;
        enable = en;
`ifdef EXMEM_FLUSH_EN
        flush  = fl;
`endif
        @(posedge clock);
        expSlot = modelEdge(expSlot, s, en, fl);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic en, fl;

        // Case 1: reset held low with every input nonzero
        reset_n = 1'b0;
        enable  = 1'b1;
`ifdef EXMEM_FLUSH_EN
        flush   = 1'b0;
`endif
        stim    = '1;
        expSlot = '0;
        #3;
        checkOutput("reset_before_clock");
        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("reset_with_clock");
        @(negedge clock);
        reset_n = 1'b1;

        // Case 2: fixed pattern load
        case2 = '{ir: 32'hAAAAAAAA, pc: 32'h55555555, res: 32'hF0F0F0F0,
                  br: 32'hCCCCCCCC, jp: 32'h33333333, zero: 1'b1, rw: 1'b1,
                  mr: 1'b1, mw: 1'b1, m2r: 1'b1, bs: 1'b1, js: 1'b1, rd: 5'b10101};
        applyStimulus(case2, 1'b1, 1'b0, "load_pattern");

        // Case 3: stall across two edges with inputs cleared
        applyStimulus('0, 1'b0, 1'b0, "stall_edge1");
        applyStimulus('0, 1'b0, 1'b0, "stall_edge2");

        // Case 4: inputs change mid-cycle, outputs only follow at the edge
        @(negedge clock);
        enable = 1'b1;
        stim   = randSlot();
        #1;
        checkOutput("midcycle_no_passthrough");
        #2;
        scratch = randSlot();
        stim    = scratch;
        @(posedge clock);
        expSlot = modelEdge(expSlot, scratch, 1'b1, 1'b0);
        #1;
        checkOutput("midcycle_captured");

        // Case 5: asynchronous reset pulse between edges while loaded
        #2;
        reset_n = 1'b0;
        expSlot = '0;
        #1;
        checkOutput("async_reset_pulse");
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(case2, 1'b1, 1'b0, "reload_after_reset");

`ifdef EXMEM_FLUSH_EN
        // Case 6: flushed load and flush during a stall
        applyStimulus(case2, 1'b1, 1'b1, "flush_bubble");
        applyStimulus(randSlot(), 1'b1, 1'b0, "post_flush_load");
        applyStimulus(case2, 1'b0, 1'b1, "flush_while_stalled");
`endif

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
`ifdef EXMEM_FLUSH_EN
            fl = 1'($urandom_range(0, 3) == 0);
`else
            fl = 1'b0;
`endif
            applyStimulus(randSlot(), en, fl, $sformatf("random_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
